// File: rtl/ddr_pkg.sv
// Shared DDR definitions: command encodings, bank codes and init FSM states.
// Also used by the DDR controller for its own command bus.
package ddr_pkg;

  localparam int CNT_W = 16;

  localparam logic [3:0] CMD_NOP = 4'b0111;
  localparam logic [3:0] CMD_PRE = 4'b0010;
  localparam logic [3:0] CMD_REF = 4'b0001;
  localparam logic [3:0] CMD_MRS = 4'b0000;

  localparam logic [1:0] BA_MRS  = 2'b00;
  localparam logic [1:0] BA_EMRS = 2'b01;

  localparam int A10 = 10;

  typedef enum logic [3:0] {
    S_PWRUP,
    S_CKE_NOP,
    S_PRE1,
    S_EMRS,
    S_MRS_DLLRST,
    S_PRE2,
    S_REF1,
    S_REF2,
    S_MRS,
    S_DONE
  } state_t;

  // Counter preload: a zero wait still costs one cycle.
  function automatic logic [CNT_W-1:0] wait_ld(input int unsigned p);
    return (p < 2) ? '0 : CNT_W'(p - 1);
  endfunction

endpackage

// File: rtl/ddr_init_seq.sv
// JEDEC DDR SDRAM power-up/init command sequencer, clk133_p domain.
// Define DDR_INIT_REINIT_EN to add reinitReq (rerun the sequence from DONE).
module ddr_init_seq
  import ddr_pkg::*;
#(
  parameter int unsigned T_PWRUP      = 26600,
  parameter int unsigned T_NOP        = 54,
  parameter int unsigned T_RP         = 3,
  parameter int unsigned T_MRD        = 2,
  parameter int unsigned T_RFC        = 10,
  parameter int unsigned T_DLL        = 200,
  parameter logic [12:0] MODE_REG     = 13'h0021,
  parameter logic [12:0] EXT_MODE_REG = 13'h0000
) (
  input  logic        clk,
  input  logic        rstN,
`ifdef DDR_INIT_REINIT_EN
  input  logic        reinitReq,
`endif
  output logic        cke,
  output logic        csN,
  output logic        rasN,
  output logic        casN,
  output logic        weN,
  output logic [1:0]  ba,
  output logic [12:0] addr,
  output logic        initDone
);

  localparam logic [12:0] DLL_RST = 13'h0100;

  state_t           r_state, w_state;
  logic [CNT_W-1:0] r_cnt, w_cnt;
  logic             r_cke, w_cke;
  logic [3:0]       r_cmd, w_cmd;
  logic [1:0]       r_ba, w_ba;
  logic [12:0]      r_addr, w_addr;
  logic             r_done, w_done;
  logic             w_exp;

  assign w_exp = (r_cnt == '0);

  // Outputs are computed for the state being entered, then registered.
  always_comb begin
    w_state = r_state;
    w_cnt   = w_exp ? '0 : r_cnt - 1'b1;
    w_cke   = r_cke;
    w_cmd   = CMD_NOP;
    w_ba    = '0;
    w_addr  = '0;
    w_done  = r_done;
    unique case (r_state)
      S_PWRUP: if (w_exp) begin
        w_state = S_CKE_NOP;
        w_cnt   = wait_ld(T_NOP);
        w_cke   = 1'b1;
      end
      S_CKE_NOP: if (w_exp) begin
        w_state     = S_PRE1;
        w_cnt       = wait_ld(T_RP);
        w_cmd       = CMD_PRE;
        w_addr[A10] = 1'b1;
      end
      S_PRE1: if (w_exp) begin
        w_state = S_EMRS;
        w_cnt   = wait_ld(T_MRD);
        w_cmd   = CMD_MRS;
        w_ba    = BA_EMRS;
        w_addr  = EXT_MODE_REG;
      end
      S_EMRS: if (w_exp) begin
        w_state = S_MRS_DLLRST;
        w_cnt   = wait_ld(T_MRD);
        w_cmd   = CMD_MRS;
        w_ba    = BA_MRS;
        w_addr  = MODE_REG | DLL_RST;
      end
      S_MRS_DLLRST: if (w_exp) begin
        w_state     = S_PRE2;
        w_cnt       = wait_ld(T_RP);
        w_cmd       = CMD_PRE;
        w_addr[A10] = 1'b1;
      end
      S_PRE2: if (w_exp) begin
        w_state = S_REF1;
        w_cnt   = wait_ld(T_RFC);
        w_cmd   = CMD_REF;
      end
      S_REF1: if (w_exp) begin
        w_state = S_REF2;
        w_cnt   = wait_ld(T_RFC);
        w_cmd   = CMD_REF;
      end
      S_REF2: if (w_exp) begin
        w_state = S_MRS;
        w_cnt   = wait_ld(T_DLL);
        w_cmd   = CMD_MRS;
        w_ba    = BA_MRS;
        w_addr  = MODE_REG;
      end
      S_MRS: if (w_exp) begin
        w_state = S_DONE;
        w_done  = 1'b1;
      end
      S_DONE: begin
`ifdef DDR_INIT_REINIT_EN
        if (reinitReq) begin
          w_state = S_PWRUP;
          w_cnt   = wait_ld(T_PWRUP);
          w_cke   = 1'b0;
          w_done  = 1'b0;
        end
`endif
      end
      default: begin
        w_state = S_PWRUP;
        w_cnt   = wait_ld(T_PWRUP);
        w_cke   = 1'b0;
        w_done  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      r_state <= S_PWRUP;
      r_cnt   <= wait_ld(T_PWRUP);
      r_cke   <= 1'b0;
      r_cmd   <= CMD_NOP;
      r_ba    <= '0;
      r_addr  <= '0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state;
      r_cnt   <= w_cnt;
      r_cke   <= w_cke;
      r_cmd   <= w_cmd;
      r_ba    <= w_ba;
      r_addr  <= w_addr;
      r_done  <= w_done;
    end
  end

  assign cke                    = r_cke;
  assign {csN, rasN, casN, weN} = r_cmd;
  assign ba                     = r_ba;
  assign addr                   = r_addr;
  assign initDone               = r_done;

endmodule

// File: tb/tb_ddr_init_seq.sv
// Directed bench for ddr_init_seq: small-parameter timing table,
// async mid-sequence reset, default-parameter latency, DONE hold, reinit.
module tb_ddr_init_seq;

  localparam logic [3:0] NOP = 4'b0111;
  localparam logic [3:0] PRE = 4'b0010;
  localparam logic [3:0] REF = 4'b0001;
  localparam logic [3:0] MRS = 4'b0000;

  typedef struct {
    int          cyc;
    logic [3:0]  cmd;
    logic [1:0]  ba;
    logic [1:0]  bam;
    logic [12:0] addr;
    logic [12:0] am;
  } vec_t;

  vec_t vec [8];

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rstN_s, rstN_d;
  logic        cke_s, csN_s, rasN_s, casN_s, weN_s, done_s;
  logic [1:0]  ba_s;
  logic [12:0] addr_s;
  logic        cke_d, csN_d, rasN_d, casN_d, weN_d, done_d;
  logic [1:0]  ba_d;
  logic [12:0] addr_d;
`ifdef DDR_INIT_REINIT_EN
  logic        reinit_s;
  logic        reinit_d;
`endif

  int checks = 0;
  int passed = 0;

  ddr_init_seq #(
    .T_PWRUP(8), .T_NOP(4), .T_RP(2),
    .T_MRD(2), .T_RFC(3), .T_DLL(5)
  ) dut_s (
    .clk(clk), .rstN(rstN_s),
`ifdef DDR_INIT_REINIT_EN
    .reinitReq(reinit_s),
`endif
    .cke(cke_s), .csN(csN_s), .rasN(rasN_s),
    .casN(casN_s), .weN(weN_s), .ba(ba_s),
    .addr(addr_s), .initDone(done_s)
  );

  ddr_init_seq dut_d (
    .clk(clk), .rstN(rstN_d),
`ifdef DDR_INIT_REINIT_EN
    .reinitReq(reinit_d),
`endif
    .cke(cke_d), .csN(csN_d), .rasN(rasN_d),
    .casN(casN_d), .weN(weN_d), .ba(ba_d),
    .addr(addr_d), .initDone(done_d)
  );

  task automatic chk_reset(input string nm);
    checks++;
    if (cke_s !== 1'b0 || {csN_s, rasN_s, casN_s, weN_s} !== NOP ||
        ba_s !== 2'b00 || addr_s !== 13'h0 || done_s !== 1'b0)
      $display("FAIL %s: got cke=%b cmd=%b ba=%b addr=%h done=%b, need 0 0111 00 0000 0",
               nm, cke_s, {csN_s, rasN_s, casN_s, weN_s}, ba_s, addr_s, done_s);
    else passed++;
  endtask

  // Expected outputs c cycles after sequence start (small parameters).
  task automatic chk_cycle(input int c);
    logic        ecke, edone;
    logic [3:0]  ecmd, gcmd;
    logic [1:0]  eba, bam;
    logic [12:0] eaddr, am;
    ecke  = (c >= 8);
    edone = (c >= 31);
    ecmd  = NOP;
    eba   = '0; bam = '0;
    eaddr = '0; am  = '0;
    foreach (vec[i]) if (vec[i].cyc == c) begin
      ecmd = vec[i].cmd; eba = vec[i].ba; bam = vec[i].bam;
      eaddr = vec[i].addr; am = vec[i].am;
    end
    gcmd = {csN_s, rasN_s, casN_s, weN_s};
    checks++;
    if (cke_s !== ecke || gcmd !== ecmd || done_s !== edone ||
        (ba_s & bam) !== eba || (addr_s & am) !== eaddr)
      $display("FAIL cycle %0d: got cke=%b cmd=%b ba=%b addr=%h done=%b, need cke=%b cmd=%b ba=%b addr=%h(mask %h) done=%b",
               c, cke_s, gcmd, ba_s, addr_s, done_s,
               ecke, ecmd, eba, eaddr, am, edone);
    else passed++;
  endtask

  // Check cycles 0..last; optionally pulse reinitReq before the edge after cycle pc.
  task automatic run_seq(input int last, input int pc);
    for (int c = 0; c <= last; c++) begin
      chk_cycle(c);
      if (c == last) break;
`ifdef DDR_INIT_REINIT_EN
      reinit_s = (c == pc);
`else
      if (c == pc) $display("note: reinit pulse skipped at cycle %0d", c);
`endif
      @(posedge clk);
      @(negedge clk);
    end
`ifdef DDR_INIT_REINIT_EN
    reinit_s = 1'b0;
`endif
  endtask

  initial begin
    int first, bad;
    vec[0] = '{12, PRE, 2'b00, 2'b00, 13'h0400, 13'h0400};
    vec[1] = '{14, MRS, 2'b01, 2'b11, 13'h0000, 13'h1fff};
    vec[2] = '{16, MRS, 2'b00, 2'b11, 13'h0121, 13'h1fff};
    vec[3] = '{18, PRE, 2'b00, 2'b00, 13'h0400, 13'h0400};
    vec[4] = '{20, REF, 2'b00, 2'b00, 13'h0000, 13'h0000};
    vec[5] = '{23, REF, 2'b00, 2'b00, 13'h0000, 13'h0000};
    vec[6] = '{26, MRS, 2'b00, 2'b11, 13'h0021, 13'h1fff};
    vec[7] = '{-1, NOP, 2'b00, 2'b00, 13'h0000, 13'h0000};

    rstN_s = 1'b0;
    rstN_d = 1'b0;
`ifdef DDR_INIT_REINIT_EN
    reinit_s = 1'b0;
    reinit_d = 1'b0;
`endif
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_reset("reset_state");

    rstN_s = 1'b1;
    run_seq(21, -1);

    // Async reset between the two refreshes, away from any clock edge.
    #1 rstN_s = 1'b0;
    #1 chk_reset("async_reset");
    repeat (2) @(posedge clk);
    @(negedge clk);
    rstN_s = 1'b1;
    run_seq(35, -1);

    bad = 0;
    for (int i = 0; i < 1000; i++) begin
      @(posedge clk);
      @(negedge clk);
      if (done_s !== 1'b1 || cke_s !== 1'b1 ||
          {csN_s, rasN_s, casN_s, weN_s} !== NOP) bad++;
    end
    checks++;
    if (bad != 0) $display("FAIL done_hold: %0d bad cycles, need 0", bad);
    else passed++;

`ifdef DDR_INIT_REINIT_EN
    reinit_s = 1'b1;
    @(posedge clk);
    @(negedge clk);
    reinit_s = 1'b0;
    // Cycle 0 of the rerun: initDone and cke drop, NOP driven.
    run_seq(33, 21);
`endif

    rstN_d = 1'b1;
    first = -1;
    bad   = 0;
    for (int c = 0; c <= 27000; c++) begin
      if (done_d === 1'b1) begin
        first = c;
        break;
      end
      if (cke_d !== (c >= 26600)) bad++;
      @(posedge clk);
      @(negedge clk);
    end
    checks++;
    if (first < 26883 || first > 26885)
      $display("FAIL default_latency: initDone at cycle %0d, need 26884 +-1", first);
    else passed++;
    checks++;
    if (bad != 0) $display("FAIL default_cke: %0d cycles wrong, need 0", bad);
    else passed++;

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/ddr_init_seq.md
Name: ddr_init_seq

Overview:
- Consumer of the clock generator's reset and 133 MHz DDR clock.
- After reset release, runs the JEDEC DDR SDRAM power-up and initialization command sequence on the command/address pins.
- Then raises initDone, and the DDR controller takes over the bus.
- Runs entirely in the clk133_p domain; `rst` from the clock generator is inverted to rstN at instantiation.

Parameters:
- T_PWRUP, 26600, cycles of stable clock with CKE low before first command (200 us at 133 MHz)
- T_NOP, 54, cycles of NOP with CKE high before PRECHARGE ALL (400 ns)
- T_RP, 3, cycles after PRECHARGE before next command
- T_MRD, 2, cycles after EMRS/MRS before next command
- T_RFC, 10, cycles after AUTO REFRESH before next command
- T_DLL, 200, cycles after DLL-reset MRS before initDone
- MODE_REG, 13'h0021, MRS operand (BL=2, sequential, CL=2); DLL-reset variant is MODE_REG | 13'h0100
- EXT_MODE_REG, 13'h0000, EMRS operand (DLL enable, full drive)

Ports:
- clk  input  1  clk133_p DDR clock
- rstN  input  1  asynchronous active-low reset
- cke  output  1  SDRAM clock enable
- csN  output  1  chip select, active low
- rasN  output  1  row address strobe, active low
- casN  output  1  column address strobe, active low
- weN  output  1  write enable, active low
- ba  output  2  bank address
- addr  output  13  address / mode operand
- initDone  output  1  high once sequence complete; stays high until reset

Behaviour:
- All outputs are registered.
- Reset values: cke=0, {csN,rasN,casN,weN}=4'b0111 (NOP), ba=0, addr=0, initDone=0.
- Commands, as {csN,rasN,casN,weN}:
  - NOP 0111
  - PRECHARGE 0010, with addr[10]=1
  - AUTO REFRESH 0001
  - MRS/EMRS 0000, with ba=00 for MRS and 01 for EMRS
- Each command is asserted for exactly one cycle; NOP is driven in every other cycle.
- One down-counter of 16 bits is shared by all waits. It is loaded with the wait value minus 1 on entry to a wait state; the state advances on the cycle the count reaches 0.
- FSM states and order:
  - PWRUP (cke=0, wait T_PWRUP)
  - CKE_NOP (cke=1, wait T_NOP)
  - PRE1 (cmd, wait T_RP)
  - EMRS (wait T_MRD)
  - MRS_DLLRST (wait T_MRD)
  - PRE2 (wait T_RP)
  - REF1 (wait T_RFC)
  - REF2 (wait T_RFC)
  - MRS (MODE_REG, wait T_DLL)
  - DONE
- Each command state issues its command on its first cycle, then NOP until the wait expires.
- cke rises on the first cycle of CKE_NOP and stays 1 through DONE.
- In DONE: initDone=1 and NOP is driven; the controller muxes the bus away from this block once initDone is seen.
- Total latency from rstN release to initDone (default parameters): T_PWRUP + T_NOP + 2·T_RP + 2·T_MRD + 2·T_RFC + T_DLL cycles, within ±1 cycle.
- Reset asserted mid-sequence: all outputs return to reset values immediately (asynchronously); the sequence restarts from PWRUP after release.
- Any parameter set to 0 is treated as 1, i.e. a minimum one-cycle wait.

Optional Feature:
- Macro: DDR_INIT_REINIT_EN.
- Enabled:
  - Adds input port reinitReq (1 bit).
  - A reinitReq high sampled in DONE clears initDone next cycle, drives cke=0 and NOP, and re-enters PWRUP, running the full sequence again.
  - reinitReq is ignored in all other states.
- Disabled: no port; DONE is terminal until reset.

Decomposition:
- Shared package ddr_pkg holds:
  - 4-bit command encodings (CMD_NOP, CMD_PRE, CMD_REF, CMD_MRS)
  - the FSM state enumeration
  - bank codes BA_MRS=2'b00, BA_EMRS=2'b01
  - the A10 precharge-all bit index
- The DDR controller reuses the command encodings from the same package.
- No sub-module: one FSM plus the shared wait counter.

Test Plan:
- Small parameters (T_PWRUP=8, T_NOP=4, T_RP=2, T_MRD=2, T_RFC=3, T_DLL=5), reset release:
  - cke rises at cycle 8.
  - PRECHARGE (addr[10]=1) at cycle 12.
  - EMRS (ba=01, addr=0) at 14.
  - MRS (addr=13'h0121) at 16.
  - PRECHARGE at 18.
  - REF at 20 and 23.
  - MRS (addr=13'h0021) at 26.
  - initDone at 31.
- Check every cycle between commands is NOP 0111, and every command lasts exactly one cycle.
- Assert rstN low at cycle 21 (between REFs) -> outputs reset asynchronously; after release the sequence repeats from PWRUP with identical timing.
- Default parameters -> initDone after 26600+54+6+4+20+200 = 26884 cycles (±1); cke=0 for the first 26600 cycles.
- Hold in DONE for 1000 cycles -> initDone stays 1, cmd stays NOP, cke stays 1.
- DDR_INIT_REINIT_EN defined:
  - reinitReq pulse in DONE -> initDone=0 and cke=0 next cycle, full sequence re-runs.
  - reinitReq pulse during REF1 -> no effect.
